// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, muldiv results drain from a FIFO.
// Latency: 1 cycle from selection to w_*; an accepted muldiv result reaches w_* no earlier than 2 cycles later.
// Backpressure: md_ready drops when the FIFO is full or clk_enable is low; the pipeline is never stalled here.
module writeback_arbiter #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_address,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              md_issue,
   input  logic [ADDR_W-1:0] md_issue_address,
   input  logic              md_valid,
   input  logic [ADDR_W-1:0] md_address,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic [ADDR_W-1:0] r_address1,
   input  logic [ADDR_W-1:0] r_address2,
   output logic              stall,
   output logic              w_enable,
   output logic [ADDR_W-1:0] w_address,
   output logic [DATA_W-1:0] w_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int NREG  = 1 << ADDR_W;

   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pending_next;

   logic              pipe_write;
   logic              fifo_empty;
   logic              enq;
   logic              pop;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   // md_ready depends only on state and clk_enable, never on md_valid.
   assign md_ready   = clk_enable && (count != CNT_W'(DEPTH));
   assign pipe_write = pipe_valid && (pipe_address != '0);
   assign fifo_empty = (count == '0);
   // Results addressed to r0 are accepted and silently dropped.
   assign enq        = md_valid && md_ready && (md_address != '0);
   // FIFO only drains into cycles the pipeline leaves idle.
   assign pop        = clk_enable && !pipe_write && !fifo_empty;
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   // FIFO storage: payload needs no reset, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr[wr_ptr] <= md_address;
         fifo_data[wr_ptr] <= md_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clk_enable) begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Write-port selection: pipeline first, then FIFO head; address/data hold when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_enable  <= 1'b0;
         w_address <= '0;
         w_data    <= '0;
      end else if (clk_enable) begin
         if (pipe_write) begin
            w_enable  <= 1'b1;
            w_address <= pipe_address;
            w_data    <= pipe_data;
         end else if (pop) begin
            w_enable  <= 1'b1;
            w_address <= head_addr;
            w_data    <= head_data;
         end else begin
            w_enable  <= 1'b0;
         end
      end
   end

   // Scoreboard next state: clear on pop of that register, then set on issue so set wins.
   always_comb begin
      pending_next = pending;
      if (pop) pending_next[head_addr] = 1'b0;
      if (md_issue && (md_issue_address != '0)) pending_next[md_issue_address] = 1'b1;
      pending_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else if (clk_enable) begin
         pending <= pending_next;
      end
   end

   // Decode stall from registered scoreboard only; r0 never stalls.
   always_comb begin
      stall = ((r_address1 != '0) && pending[r_address1]) ||
              ((r_address2 != '0) && pending[r_address2]);
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Drives the register file's single write port (w_address/w_data/w_enable) from two result producers:
  - the in-order pipeline writeback (ALU/load results);
  - the long-latency multiply/divide unit (valid/ready handshake).
- Buffers muldiv results in a small FIFO and drains them into idle write-port cycles.
- Tracks registers with an outstanding muldiv result in a scoreboard and raises stall to decode when a source register is pending.

Parameters:
DEPTH, 2, muldiv result FIFO entries (power of two, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
clk_enable  input  1  global clock enable; when low, no state changes
pipe_valid  input  1  pipeline has a result to write this cycle
pipe_address  input  ADDR_W  pipeline destination register
pipe_data  input  DATA_W  pipeline result
md_issue  input  1  muldiv op issued this cycle; marks md_issue_address pending
md_issue_address  input  ADDR_W  muldiv destination register
md_valid  input  1  muldiv result available
md_address  input  ADDR_W  muldiv result destination
md_data  input  DATA_W  muldiv result
md_ready  output  1  FIFO can accept a muldiv result
r_address1  input  ADDR_W  decode source register 1
r_address2  input  ADDR_W  decode source register 2
stall  output  1  a decode source register is pending
w_enable  output  1  register file write enable (registered)
w_address  output  ADDR_W  register file write address (registered)
w_data  output  DATA_W  register file write data (registered)

Behaviour:
- Reset, asynchronous:
  - w_enable=0, w_address=0, w_data=0;
  - FIFO empty (count=0, read/write pointers 0);
  - all scoreboard bits clear.
  - After reset deasserts: md_ready=1, stall=0.
- All updates occur only on a clk edge with clk_enable=1. With clk_enable=0 all registers hold and md_ready=0.
- md_ready = clk_enable && (count != DEPTH). It depends only on state and clk_enable; there is no combinational path from md_valid.
- Accept: md_valid && md_ready.
  - md_address!=0: enqueue {md_address, md_data}.
  - md_address==0: consume and drop; nothing is enqueued.
- Write-port selection each enabled cycle, with pipe_write = pipe_valid && pipe_address!=0:
  - pipe_write: next w_* = pipe entry; FIFO does not drain.
  - else if FIFO non-empty: next w_* = FIFO head; pop.
  - else: next w_enable=0. w_address/w_data hold their previous values.
- Latency: 1 cycle from selection to w_* outputs. A muldiv result accepted in cycle N can appear on w_* at earliest in cycle N+2: enqueue at N, pop at N+1.
- Simultaneous enqueue and pop with FIFO full: accept is blocked (md_ready=0 when full). Enqueue and pop in the same cycle otherwise leaves count unchanged.
- FIFO pointers wrap modulo DEPTH.
- Scoreboard, one bit per register (bit 0 constant 0):
  - set on md_issue && md_issue_address!=0;
  - cleared when a FIFO pop writes that address;
  - set and clear of the same register in the same cycle: set wins.
- stall = (r_address1!=0 && pending[r_address1]) || (r_address2!=0 && pending[r_address2]). Combinational from the scoreboard; a bit set this cycle affects stall next cycle.
- Protocol rules (bench asserts):
  - upstream never issues a muldiv to an already pending register;
  - pipe_address never targets a pending register.
- Ordering: muldiv results are written in acceptance order. A pipeline write is never delayed.

Test Plan:
- Reset mid-operation: fill FIFO with 2 entries, assert reset -> w_enable=0, md_ready=1 after release, stall=0, no stale entries written afterward.
- Pipeline only: pipe_valid=1, pipe_address=5, pipe_data=0xDEADBEEF at cycle N -> w_enable=1, w_address=5, w_data=0xDEADBEEF at N+1. pipe_address=0 -> w_enable=0.
- Contention:
  - md_issue r7; later md_valid r7=0x1234 accepted while pipe_valid writes r3 for 3 consecutive cycles;
  - expect r3 written 3 cycles, then r7=0x1234 on the first idle cycle;
  - stall=1 for r_address1=7 until the cycle after the r7 write pops.
- Full FIFO: block pipeline idle cycles with continuous pipe writes; accept 2 md results -> md_ready=0. One more md_valid is held, not lost. Release the pipe -> writes occur in order, md_ready returns 1 after the first pop.
- Scoreboard same-cycle set/clear: r9 pending and its result popping while md_issue r9 is asserted -> pending[9] stays 1, stall with r_address2=9 remains 1.
- clk_enable=0 for 4 cycles with FIFO non-empty and pipe_valid=1 -> md_ready=0, w_* hold, count unchanged. On re-enable, normal priority resumes.
